// File: rtl/frag_splitter.sv
// Drains a packet from the byte FIFO in 1-4 byte reads and re-emits it as fragments of at most cfg_frag_len bytes.
// Define FRAG_HDR_EN to prefix each fragment with a header word; without it fragments are payload only.
module frag_splitter #(
  parameter int FRAG_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [7:0]        pkt_id,
  input  logic [FRAG_W-1:0] cfg_frag_len,
  output logic              pkt_busy,
  output logic              cfg_err,
  input  logic [4:0]        fifo_index,
  input  logic [31:0]       fifo_dout,
  output logic              fifo_rd_en,
  output logic [3:0]        fifo_rd_bytes,
  output logic [31:0]       m_data,
  output logic [3:0]        m_keep,
  output logic              m_sof,
  output logic              m_eof,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [2:0] {IDLE, HDR, REQ, WAIT, OUT} state_t;

`ifdef FRAG_HDR_EN
  localparam state_t FRAG_ENTRY = HDR;
`else
  localparam state_t FRAG_ENTRY = REQ;
`endif

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  pkt_rem, pkt_rem_dec;
  logic [FRAG_W-1:0] frag_rem, frag_rem_dec, cfg_q;
  logic [31:0]       data_q;
  logic [2:0]        n;
  logic              start_ok, rd_ok, out_done;

`ifdef FRAG_HDR_EN
  typedef struct packed {
    logic [7:0]  seq;
    logic        more;
    logic [2:0]  rsvd;
    logic [11:0] frag_len;
    logic [7:0]  id;
  } hdr_t;

  logic [7:0] seq, id_q;
  hdr_t       hdr;

  assign hdr = '{seq: seq, more: (pkt_rem > LEN_W'(cfg_q)), rsvd: 3'b000,
                 frag_len: 12'(frag_rem), id: id_q};
`else
  logic first_q;
  logic unused_pkt_id;

  assign unused_pkt_id = ^pkt_id;
`endif

  function automatic logic [FRAG_W-1:0] frag_min(input logic [LEN_W-1:0] rem,
                                                 input logic [FRAG_W-1:0] cfg);
    if (rem > LEN_W'(cfg)) return cfg;
    else return FRAG_W'(rem);
  endfunction

  assign n            = (frag_rem >= FRAG_W'(4)) ? 3'd4 : frag_rem[2:0];
  assign pkt_rem_dec  = pkt_rem - LEN_W'(n);
  assign frag_rem_dec = frag_rem - FRAG_W'(n);
  assign start_ok     = pkt_start && (pkt_len != '0) && (cfg_frag_len != '0);
  assign rd_ok        = fifo_index >= {2'b00, n};
  assign out_done     = (state == OUT) && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_ok) state_nxt = FRAG_ENTRY;
`ifdef FRAG_HDR_EN
      HDR:  if (m_ready) state_nxt = REQ;
`endif
      REQ:  if (rd_ok) state_nxt = WAIT;
      WAIT: state_nxt = OUT;
      OUT: begin
        if (m_ready) begin
          if (frag_rem_dec != '0)     state_nxt = REQ;
          else if (pkt_rem_dec != '0) state_nxt = FRAG_ENTRY;
          else                        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_busy      = (state != IDLE);
    m_valid       = 1'b0;
    m_data        = '0;
    m_keep        = '0;
    m_sof         = 1'b0;
    m_eof         = 1'b0;
    fifo_rd_en    = 1'b0;
    fifo_rd_bytes = '0;
    unique case (state)
`ifdef FRAG_HDR_EN
      HDR: begin
        m_valid = 1'b1;
        m_data  = hdr;
        m_keep  = 4'hF;
        m_sof   = 1'b1;
      end
`endif
      REQ: begin
        if (rd_ok) begin
          fifo_rd_en    = 1'b1;
          fifo_rd_bytes = {1'b0, n};
        end
      end
      OUT: begin
        m_valid = 1'b1;
        m_data  = data_q;
        m_eof   = (frag_rem == FRAG_W'(n));
`ifndef FRAG_HDR_EN
        m_sof   = first_q;
`endif
        case (n)
          3'd1:    m_keep = 4'b1000;
          3'd2:    m_keep = 4'b1100;
          3'd3:    m_keep = 4'b1110;
          default: m_keep = 4'b1111;
        endcase
      end
      default: ;
    endcase
  end

  // frag_rem stays put from REQ through OUT, so n and m_keep are stable under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_rem  <= '0;
      frag_rem <= '0;
      cfg_q    <= '0;
      data_q   <= '0;
      cfg_err  <= 1'b0;
`ifdef FRAG_HDR_EN
      seq      <= '0;
      id_q     <= '0;
`else
      first_q  <= 1'b0;
`endif
    end else begin
      cfg_err <= (state == IDLE) && pkt_start && !start_ok;
      if ((state == IDLE) && start_ok) begin
        pkt_rem  <= pkt_len;
        cfg_q    <= cfg_frag_len;
        frag_rem <= frag_min(pkt_len, cfg_frag_len);
`ifdef FRAG_HDR_EN
        seq      <= '0;
        id_q     <= pkt_id;
`else
        first_q  <= 1'b1;
`endif
      end
      if (state == WAIT) data_q <= fifo_dout;
      if (out_done) begin
        pkt_rem  <= pkt_rem_dec;
        frag_rem <= frag_rem_dec;
`ifndef FRAG_HDR_EN
        first_q  <= 1'b0;
`endif
        if ((frag_rem_dec == '0) && (pkt_rem_dec != '0)) begin
          frag_rem <= frag_min(pkt_rem_dec, cfg_q);
`ifdef FRAG_HDR_EN
          seq      <= seq + 8'd1;
`else
          first_q  <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_frag_splitter.sv
// Randomized bench for frag_splitter: a byte-queue FIFO model feeds the DUT and a fragment-list model predicts the stream.
`timescale 1ns/1ps
module tb_frag_splitter;
  localparam int FRAG_W = 12;
  localparam int LEN_W  = 16;
`ifdef FRAG_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_start;
  logic [LEN_W-1:0]  pkt_len;
  logic [7:0]        pkt_id;
  logic [FRAG_W-1:0] cfg_frag_len;
  logic              pkt_busy, cfg_err;
  logic [4:0]        fifo_index;
  logic [31:0]       fifo_dout;
  logic              fifo_rd_en;
  logic [3:0]        fifo_rd_bytes;
  logic [31:0]       m_data;
  logic [3:0]        m_keep;
  logic              m_sof, m_eof, m_valid, m_ready;

  frag_splitter #(.FRAG_W(FRAG_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_len(pkt_len), .pkt_id(pkt_id),
    .cfg_frag_len(cfg_frag_len), .pkt_busy(pkt_busy), .cfg_err(cfg_err),
    .fifo_index(fifo_index), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_bytes(fifo_rd_bytes), .m_data(m_data), .m_keep(m_keep), .m_sof(m_sof),
    .m_eof(m_eof), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [37:0] expq[$];
  logic [7:0]  pb[$];
  logic [7:0]  fq[$];
  int          avail = 0, pend = 0, rd_count = 0, last_rd = 0;
  int          ready_mode = 1, avail_mode = 1;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: {data, keep, sof, eof} per word, built fragment by fragment from the byte list
  task automatic model_pkt(input int len, input int cfg, input logic [7:0] id);
    int rem, pos, seq, fl, n;
    bit more, first;
    logic [31:0] w;
    logic [3:0]  k;
    rem = len; pos = 0; seq = 0;
    while (rem > 0) begin
      fl = (rem < cfg) ? rem : cfg;
      more = (rem > cfg);
      first = 1'b1;
      if (HDR_ON) expq.push_back({seq[7:0], more, 3'b000, fl[11:0], id, 4'hF, 1'b1, 1'b0});
      while (fl > 0) begin
        n = (fl < 4) ? fl : 4;
        w = '0; k = '0;
        for (int i = 0; i < n; i++) begin
          w[31-8*i -: 8] = pb[pos+i];
          k[3-i] = 1'b1;
        end
        expq.push_back({w, k, (!HDR_ON && first), (fl == n)});
        fl -= n; rem -= n; pos += n;
        first = 1'b0;
      end
      seq = (seq + 1) % 256;
    end
  endtask

  task automatic fill_rand(input int len);
    pb.delete();
    for (int i = 0; i < len; i++) pb.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clear_bench();
    expq.delete(); fq.delete(); avail = 0; pend = 0;
  endtask

  task automatic begin_pkt(input int len, input int cfg, input logic [7:0] id);
    foreach (pb[i]) fq.push_back(pb[i]);
    model_pkt(len, cfg, id);
    pkt_start = 1'b1; pkt_len = 16'(len); cfg_frag_len = 12'(cfg); pkt_id = id;
    tick();
    pkt_start = 1'b0;
  endtask

  task automatic end_pkt(input int budget, output int lat, output int cyc);
    lat = -1; cyc = 0;
    while ((pkt_busy || expq.size() != 0) && cyc < budget) begin
      if (m_valid && lat < 0) lat = cyc + 1;
      tick();
      cyc++;
    end
    check("pkt_complete", cyc < budget, 1);
    check("pkt_words_left", expq.size(), 0);
    if (cyc >= budget) begin
      rst = 1'b1; tick(); tick(); clear_bench(); rst = 1'b0;
    end
  endtask

  task automatic run_pkt(input int len, input int cfg, input logic [7:0] id, input int budget,
                         output int lat, output int cyc);
    begin_pkt(len, cfg, id);
    end_pkt(budget, lat, cyc);
  endtask

  // FIFO model with one-cycle registered read data, plus m_ready driver
  initial begin
    logic [31:0] w;
    fifo_dout = '0; fifo_index = '0; m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        fifo_dout = '0; pend = 0; m_ready = 1'b0;
      end else begin
        if (pend != 0) begin
          w = '0;
          for (int i = 0; i < pend; i++) if (fq.size() != 0) w[31-8*i -: 8] = fq.pop_front();
          fifo_dout = w; avail -= pend; pend = 0;
        end
        if (avail_mode == 1) avail = fq.size();
        else if (avail_mode == 0 && avail < fq.size() && $urandom_range(0, 3) != 0) begin
          avail += int'($urandom_range(1, 3));
          if (avail > fq.size()) avail = fq.size();
        end
        m_ready = (ready_mode == 1) || (ready_mode == 0 && $urandom_range(0, 3) != 0);
      end
      fifo_index = (avail > 31) ? 5'd31 : (avail < 0) ? 5'd0 : 5'(avail);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) begin
        check("rd_while_valid", m_valid, 0);
        check("rd_underflow", fifo_rd_bytes <= fifo_index, 1);
        pend = int'(fifo_rd_bytes);
        last_rd = int'(fifo_rd_bytes);
        rd_count++;
      end
      if (prev_stall) check("stall_stable", {m_data, m_keep, m_sof, m_eof}, prev_word);
      if (m_valid && m_ready) begin
        check("word_expected", expq.size() != 0, 1);
        if (expq.size() != 0) check("word", {m_data, m_keep, m_sof, m_eof}, expq.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_data, m_keep, m_sof, m_eof};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, r0, len, cfg;
    rst = 1'b1; pkt_start = 1'b0; pkt_len = '0; pkt_id = '0; cfg_frag_len = '0;
    repeat (3) tick();
    check("reset_outputs", {pkt_busy, cfg_err, fifo_rd_en, fifo_rd_bytes, m_data, m_keep,
                            m_sof, m_eof, m_valid}, '0);
    rst = 1'b0;
    ready_mode = 1; avail_mode = 1;
    tick();

    // Reference example: 10 bytes in fragments of 8
    pb.delete();
    for (int i = 1; i <= 10; i++) pb.push_back(8'(i));
    run_pkt(10, 8, 8'h3C, 200, lat, cyc);
    check("first_valid_latency", lat, HDR_ON ? 1 : 3);
    check("busy_cycles_10_8", cyc, HDR_ON ? 11 : 9);

    // Starvation: no read until four bytes are available
    fill_rand(4);
    avail_mode = 2; avail = 2;
    begin_pkt(4, 8, 8'h11);
    r0 = rd_count;
    repeat (10) tick();
    check("starve_no_read", rd_count - r0, 0);
    avail = 4;
    tick();
    check("starve_one_read", rd_count - r0, 1);
    check("starve_rd_bytes", last_rd, 4);
    end_pkt(200, lat, cyc);
    avail_mode = 1;

    // Backpressure on the first payload word
    fill_rand(8);
    begin_pkt(8, 8, 8'h42);
    r0 = rd_count; cyc = 0;
    while (rd_count == r0 && cyc < 20) begin tick(); cyc++; end
    ready_mode = 2;
    tick();
    check("bp_valid", m_valid, 1);
    r0 = rd_count;
    repeat (5) begin
      tick();
      check("bp_hold_data", m_data, expq[0][37:6]);
      check("bp_valid_held", m_valid, 1);
    end
    check("bp_no_read", rd_count - r0, 0);
    ready_mode = 1;
    end_pkt(200, lat, cyc);

    // Rejected configurations
    for (int k = 0; k < 2; k++) begin
      r0 = rd_count;
      pkt_start = 1'b1; pkt_len = (k == 0) ? 16'd0 : 16'd7;
      cfg_frag_len = (k == 0) ? 12'd8 : 12'd0; pkt_id = 8'h5A;
      tick();
      pkt_start = 1'b0;
      check("cfgerr_pulse", cfg_err, 1);
      check("cfgerr_not_busy", pkt_busy, 0);
      tick();
      check("cfgerr_one_cycle", cfg_err, 0);
      check("cfgerr_idle", {pkt_busy, m_valid, fifo_rd_en}, 0);
      check("cfgerr_no_read", rd_count - r0, 0);
    end

    // Asynchronous reset in the middle of a fragment
    ready_mode = 0; avail_mode = 0;
    fill_rand(20);
    begin_pkt(20, 8, 8'h77);
    repeat (6) tick();
    check("busy_before_reset", pkt_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {pkt_busy, cfg_err, fifo_rd_en, fifo_rd_bytes, m_data, m_keep,
                                  m_sof, m_eof, m_valid}, '0);
    clear_bench();
    tick(); tick();
    rst = 1'b0;
    ready_mode = 1; avail_mode = 1;
    tick();
    fill_rand(12);
    run_pkt(12, 5, 8'h99, 400, lat, cyc);

    // Short single-word packet
    pb.delete();
    pb.push_back(8'hAA); pb.push_back(8'hBB); pb.push_back(8'hCC);
    run_pkt(3, 8, 8'h05, 100, lat, cyc);
    check("busy_cycles_3_8", cyc, HDR_ON ? 4 : 3);

    // Randomized packets, with a start pulse while busy that must be ignored
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 40);
      cfg = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 50) : $urandom_range(1, 12);
      ready_mode = 0;
      avail_mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
      fill_rand(len);
      begin_pkt(len, cfg, 8'($urandom_range(0, 255)));
      tick();
      if (pkt_busy) begin
        pkt_start = 1'b1; pkt_len = 16'($urandom_range(0, 3)); cfg_frag_len = 12'($urandom_range(0, 3));
        tick();
        pkt_start = 1'b0;
        check("ignored_start_no_err", cfg_err, 0);
      end
      end_pkt(3000, lat, cyc);
    end

    // Sequence number wraps past 255
    ready_mode = 1; avail_mode = 1;
    tick();
    fill_rand(260);
    run_pkt(260, 1, 8'hE7, 3000, lat, cyc);
    check("busy_cycles_wrap", cyc, HDR_ON ? 1040 : 780);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frag_splitter.md
# frag_splitter

Downstream consumer of the byte-granular reassembly FIFO. It drains a packet of known length from the FIFO in 1–4-byte reads and re-emits it as a stream of fragments of configurable payload size. Each fragment is optionally prefixed with a header word. Output is a 32-bit valid/ready stream, left-aligned bytes, feeding the link framer.

## Interface
- FRAG_W, 12, width of fragment-length config and header length field
- LEN_W, 16, width of packet length
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- pkt_start  in  1  one-cycle request to split a packet; accepted only in IDLE
- pkt_len  in  LEN_W  packet length in bytes, sampled with pkt_start
- pkt_id  in  8  packet identifier, sampled with pkt_start
- cfg_frag_len  in  FRAG_W  max payload bytes per fragment, sampled with pkt_start
- pkt_busy  out  1  high from the cycle after acceptance until the last output handshake completes
- cfg_err  out  1  one-cycle pulse when pkt_start is rejected for pkt_len==0 or cfg_frag_len==0
- fifo_index  in  5  valid byte count currently held in the FIFO
- fifo_dout  in  32  FIFO read data, registered, first byte in [31:24]
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_bytes  out  4  bytes requested (1–4), 0 when idle
- m_data  out  32  output word, first byte in [31:24]
- m_keep  out  4  left-aligned byte mask (1 byte = 4'b1000)
- m_sof  out  1  first word of a fragment
- m_eof  out  1  last word of a fragment
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept

## Operation
- FSM states: IDLE, HDR, REQ, WAIT, OUT.
- IDLE: on pkt_start with nonzero pkt_len and nonzero cfg_frag_len, latch the configuration and set pkt_rem=pkt_len, seq=0. Go to HDR, or to REQ when the header is compiled out. Otherwise pulse cfg_err and stay in IDLE.
- Fragment start: frag_rem = min(cfg_frag_len, pkt_rem); more = (pkt_rem > cfg_frag_len).
- HDR: drive the header word {seq[7:0], more, 3'b000, frag_rem[11:0], pkt_id[7:0]} with m_keep=4'hF, m_sof=1, m_eof=0. Stay until m_ready, then go to REQ.
- REQ: n = min(4, frag_rem). When fifo_index >= n, assert fifo_rd_en with fifo_rd_bytes=n for one cycle and go to WAIT. Otherwise hold with no read. Underflow stalls the block; it never raises an error.
- WAIT: capture fifo_dout into m_data, set m_keep from n, and go to OUT.
- OUT: m_valid=1. m_eof=1 when this word ends the fragment (frag_rem==n). m_sof=1 only for the first payload word when the header is compiled out. On m_ready, decrement frag_rem and pkt_rem by n.
- After the OUT handshake:
  - frag_rem!=0: go to REQ.
  - frag_rem==0 and pkt_rem!=0: increment seq (wraps 255 to 0) and start the next fragment.
  - frag_rem==0 and pkt_rem==0: go to IDLE.
- Only one FIFO read is ever outstanding. fifo_rd_en is never asserted while m_valid is held unaccepted.
- pkt_start outside IDLE is ignored and does not pulse cfg_err.
- Arithmetic: counters are LEN_W wide. frag_rem is FRAG_W wide. The byte-count compare is zero-extended to 5 bits.

## Timing
- Reset values: every output is 0 (m_data, m_keep, flags, fifo_rd_bytes included), FSM=IDLE, seq=0.
- Reset mid-packet aborts immediately with no flush. FIFO contents are the upstream's concern.
- pkt_start at cycle 0 gives the header m_valid at cycle 1.
- Payload read timing: REQ read at cycle t, FIFO data valid at t+1, m_valid at t+2.
- Throughput: one payload word per 3 cycles with m_ready held high and the FIFO non-starved.
- Output stability: m_data, m_keep, m_sof and m_eof are stable while m_valid && !m_ready.
- pkt_busy falls the cycle after the final handshake. A new pkt_start is accepted that same cycle.

## Configuration
- FRAG_HDR_EN defined: a header word precedes every fragment, carrying m_sof.
- FRAG_HDR_EN undefined: HDR state is removed. Fragments are payload only, and the first payload word carries m_sof.

## Test plan
- Header on: pkt_len=10, cfg_frag_len=8, pkt_id=0x3C, FIFO holding 0x01..0x0A, m_ready=1. Expected stream:
  - 0x0080083C (sof)
  - 0x01020304 keep F
  - 0x05060708 keep F (eof)
  - 0x0100023C (sof)
  - 0x090A0000 keep C (eof)
  - pkt_busy then falls.
- Starvation: pkt_len=4 with fifo_index=2. No fifo_rd_en is issued until fifo_index reaches 4, then a single read of 4 bytes.
- Backpressure: hold m_ready=0 for 5 cycles on a payload word. m_data stays constant, no FIFO read is issued, and the word completes once m_ready=1.
- Config errors: pkt_start with pkt_len=0, or with cfg_frag_len=0, gives a cfg_err pulse, FSM stays IDLE and pkt_busy stays 0.
- Reset: assert rst mid-fragment. All outputs go to 0 asynchronously. The next pkt_start starts at seq=0.
- Header off: pkt_len=3, cfg_frag_len=8 gives one word 0xAABBCC00, keep 4'b1110, with sof and eof both set.
